rule90_reverse: RTL and testbench
=================================

Name: rule90_reverse

Overview:
- Inverse of the rule90 generation engine. Given a 512-cell state, it recovers the unique predecessor state under null (zero) boundaries, and can rewind GENS generations.
- For even N, rule90 with zero boundaries is a bijection, so the predecessor always exists and is unique.
- Sits beside rule90 in the automaton datapath. It rewinds snapshots for debug and replay, one bit-chunk per cycle through a start/busy/done handshake.

Parameters:
- N, 512, cell count; must be even and at least 4.
- STEP, 8, predecessor cells resolved per SCAN cycle; must divide N.
- GEN_W, 8, width of the generation count.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- data  input  N  state to rewind; captured on an accepted start
- gens  input  GEN_W  number of generations to rewind; captured with data
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse; q is valid from this cycle onward
- q  output  N  rewound state; holds its value until the next done

Behaviour:
- Reset (asynchronous, resetn=0):
  - q=0, busy=0, done=0, state=IDLE, internal registers cleared.
  - Reset mid-operation aborts the job; no done is produced.
- Forward rule being inverted: n[i]=p[i-1]^p[i+1], with p[-1]=p[N]=0.
- Inverse algorithm:
  - p[0] = XOR of n[1], n[3], ..., n[N-1] (all odd-index bits).
  - p[1] = n[0].
  - p[i] = n[i-2+1] ^ p[i-2] = n[i-1] ^ p[i-2], for i>=2.
- FSM:
  - IDLE: on start, capture nreg<=data and gcnt<=gens, set busy.
    - gens=0: go to FIN, so q<=data and done fires 2 cycles after start.
    - Otherwise go to SEED.
  - SEED (1 cycle): preg[0] <= reduction XOR of the odd bits of nreg; k<=0.
  - SCAN (N/STEP cycles): resolve preg[k..k+STEP-1] using the chain above, STEP-deep unrolled; k+=STEP. On the last chunk go to NEXT.
  - NEXT (1 cycle): nreg<=preg, gcnt-=1. If gcnt reaches 0 go to FIN, else go to SEED.
  - FIN (1 cycle): q<=nreg, done=1, busy=0, return to IDLE.
- Latency: 2 + GENS*(N/STEP+2) cycles from start to done. N=512, STEP=8, GENS=1 gives 68 cycles.
- start while busy is ignored, and data/gens are not re-sampled.
- start in the same cycle as done (FIN) is ignored; it is accepted from IDLE on the next cycle.
- gcnt wraps never: the count only decrements and stops at 0.
- GENS = 2^GEN_W-1 is legal.

Optional Feature:
- Macro: RULE90_REVERSE_CHECK_EN.
- When defined:
  - In NEXT, the block forward-steps preg through the rule90_step instance and compares the result with nreg.
  - Adds output chk_err (1 bit, reset 0). It is sticky-set on any mismatch and cleared on an accepted start.
  - Latency is unchanged, because the compare runs in the same NEXT cycle.
- When undefined: no chk_err port, no rule90_step instance, and latency is identical.

Decomposition:
- rule90_pkg:
  - State enum: IDLE, SEED, SCAN, NEXT, FIN.
  - Localparam CHUNKS = N/STEP.
  - Counter width function for k, and a function computing the odd-bit XOR seed.
- One sub-module, rule90_step: purely combinational forward step with zero boundaries, N-parameterised.
  - Used by the check feature.
  - Reusable by the rule90 engine.

Test Plan:
- N=8, STEP=2, data=8'b0000_0010, gens=1 -> q=8'b0000_0001. done at cycle 2+1*(4+2)=8 after start; busy high in between.
- N=512, STEP=8: start from data with only bit 256 set. Run rule90 forward 10 generations, then rewind with gens=10 -> q has only bit 256 set, at cycle 2+10*66=662; chk_err=0 with the macro defined.
- gens=0, data=random -> q=data, done pulses exactly 2 cycles after start; all-zero data with gens=5 -> q=0.
- start pulsed again at cycle 10 of a gens=1 run with different data -> ignored; q equals the first job's result.
- resetn dropped during SCAN -> q=0, busy=0 immediately, no done; a fresh start afterwards completes normally.
- Random data, gens=3, macro defined -> forward-stepping q three times reproduces data, and chk_err stays 0.

Source files
------------

// File: rtl/rule90_pkg.sv
// Shared types and helpers for the rule90 automaton blocks (rule90_reverse, rule90_step).
package rule90_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    SCAN,
    NEXT,
    FIN
  } state_e;

  localparam int unsigned N_DEF    = 512;
  localparam int unsigned STEP_DEF = 8;
  localparam int unsigned CHUNKS   = N_DEF / STEP_DEF;
  // Widest state the seed helper reduces; narrower states are zero-extended.
  localparam int unsigned N_MAX    = 2048;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic odd_xor(input logic [N_MAX-1:0] v);
    logic r;
    r = 1'b0;
    for (int unsigned i = 1; i < N_MAX; i += 2) r ^= v[i];
    return r;
  endfunction

endpackage

// File: rtl/rule90_step.sv
// One combinational rule90 generation with zero boundaries: n[i] = p[i-1] ^ p[i+1].
module rule90_step #(
  parameter int unsigned N = 512
) (
  input  logic [N-1:0] p_i,
  output logic [N-1:0] n_o
);

  assign n_o = {p_i[N-2:0], 1'b0} ^ {1'b0, p_i[N-1:1]};

endmodule

// File: rtl/rule90_reverse.sv
// Rewinds a rule90 state by GENS generations, STEP predecessor cells per cycle.
// Define RULE90_REVERSE_CHECK_EN to add a forward-step self-check and the chk_err output.
module rule90_reverse
  import rule90_pkg::*;
#(
  parameter int unsigned N     = 512,
  parameter int unsigned STEP  = 8,
  parameter int unsigned GEN_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [N-1:0]     data,
  input  logic [GEN_W-1:0] gens,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     q
`ifdef RULE90_REVERSE_CHECK_EN
  ,output logic            chk_err
`endif
);

  localparam int unsigned KW = cnt_w(N);

  state_e           state_q;
  logic [N-1:0]     nreg_q;
  logic [N-1:0]     preg_q;
  logic [GEN_W-1:0] gcnt_q;
  logic [KW-1:0]    k_q;

  logic             seed_d;
  logic [N:0]       nx;
  logic [N+1:0]     px;
  logic [STEP-1:0]  nwin;
  logic [1:0]       pprev;
  logic [STEP-1:0]  chunk_d;

  // Extended views make p[0] fall out of the same chain: n[-1] is the seed, p[-2] is 0.
  always_comb begin
    seed_d  = odd_xor(N_MAX'(nreg_q));
    nx      = {nreg_q, preg_q[0]};
    px      = {preg_q, 2'b00};
    nwin    = nx[k_q +: STEP];
    pprev   = px[k_q +: 2];
    chunk_d = '0;
    for (int unsigned j = 0; j < STEP; j++) begin
      if (j < 2) chunk_d[j] = nwin[j] ^ pprev[j];
      else       chunk_d[j] = nwin[j] ^ chunk_d[j-2];
    end
  end

`ifdef RULE90_REVERSE_CHECK_EN
  logic [N-1:0] fwd_n;

  rule90_step #(.N(N)) u_step (
    .p_i (preg_q),
    .n_o (fwd_n)
  );
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      nreg_q  <= '0;
      preg_q  <= '0;
      gcnt_q  <= '0;
      k_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      q       <= '0;
`ifdef RULE90_REVERSE_CHECK_EN
      chk_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            nreg_q  <= data;
            gcnt_q  <= gens;
            busy    <= 1'b1;
            state_q <= (gens == '0) ? FIN : SEED;
`ifdef RULE90_REVERSE_CHECK_EN
            chk_err <= 1'b0;
`endif
          end
        end
        SEED: begin
          preg_q  <= N'(seed_d);
          k_q     <= '0;
          state_q <= SCAN;
        end
        SCAN: begin
          preg_q[k_q +: STEP] <= chunk_d;
          k_q <= k_q + KW'(STEP);
          if (k_q == KW'(N - STEP)) state_q <= NEXT;
        end
        NEXT: begin
          nreg_q  <= preg_q;
          gcnt_q  <= gcnt_q - 1'b1;
          state_q <= (gcnt_q == GEN_W'(1)) ? FIN : SEED;
`ifdef RULE90_REVERSE_CHECK_EN
          if (fwd_n != nreg_q) chk_err <= 1'b1;
`endif
        end
        FIN: begin
          q       <= nreg_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rule90_reverse.sv
// Directed bench for rule90_reverse: an N=8 hand vector plus N=512 rewind jobs.
module tb_rule90_reverse;

  localparam int unsigned N     = 512;
  localparam int unsigned STEP  = 8;
  localparam int unsigned GEN_W = 8;
  localparam int unsigned LIMIT = 20000;

  logic             clk = 1'b0;
  logic             resetn;
  logic             start;
  logic [N-1:0]     data;
  logic [GEN_W-1:0] gens;
  logic             busy, done;
  logic [N-1:0]     q;

  logic             start8;
  logic [7:0]       data8;
  logic [GEN_W-1:0] gens8;
  logic             busy8, done8;
  logic [7:0]       q8;

`ifdef RULE90_REVERSE_CHECK_EN
  logic chk_err, chk_err8;
`endif

  rule90_reverse #(.N(N), .STEP(STEP), .GEN_W(GEN_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .data   (data),
    .gens   (gens),
    .busy   (busy),
    .done   (done),
    .q      (q)
`ifdef RULE90_REVERSE_CHECK_EN
    ,.chk_err (chk_err)
`endif
  );

  rule90_reverse #(.N(8), .STEP(2), .GEN_W(GEN_W)) dut8 (
    .clk    (clk),
    .resetn (resetn),
    .start  (start8),
    .data   (data8),
    .gens   (gens8),
    .busy   (busy8),
    .done   (done8),
    .q      (q8)
`ifdef RULE90_REVERSE_CHECK_EN
    ,.chk_err (chk_err8)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] fwd(input logic [N-1:0] p);
    return (p << 1) ^ (p >> 1);
  endfunction

  function automatic logic [N-1:0] fwd_n(input logic [N-1:0] p, input int unsigned g);
    logic [N-1:0] v;
    v = p;
    for (int unsigned i = 0; i < g; i++) v = fwd(v);
    return v;
  endfunction

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] v;
    for (int unsigned i = 0; i < N/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Drives one job; optionally pulses a second start at cycle intf_at with other data.
  task automatic run_job(input string tag, input logic [N-1:0] d, input logic [GEN_W-1:0] g,
                         input int unsigned intf_at, input logic [N-1:0] alt,
                         input logic [N-1:0] exp_q, input int unsigned exp_lat);
    int unsigned lat;
    logic        busy_ok;
    @(posedge clk); #1;
    start = 1'b1; data = d; gens = g;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; busy_ok = 1'b1;
    while (done !== 1'b1 && lat < LIMIT) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (intf_at != 0 && lat == intf_at) begin
        start = 1'b1; data = alt; gens = g + 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, N'(lat), N'(exp_lat));
    check({tag, "_q"}, q, exp_q);
    check({tag, "_busy_during"}, N'(busy_ok), N'(1));
    check({tag, "_busy_at_done"}, N'(busy), N'(0));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, N'(done), N'(0));
    check({tag, "_q_hold"}, q, exp_q);
  endtask

  initial begin
    logic [N-1:0] x, d, one256;
    int unsigned  lat;
    logic         busy_ok, seen;

    resetn = 1'b0; start = 1'b0; data = '0; gens = '0;
    start8 = 1'b0; data8 = '0; gens8 = '0;
    #1;
    check("reset_q", q, '0);
    check("reset_busy", N'(busy), N'(0));
    check("reset_done", N'(done), N'(0));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // N=8, STEP=2 hand vector: 0000_0010 rewinds to 0000_0001 in 8 cycles.
    @(posedge clk); #1;
    start8 = 1'b1; data8 = 8'b0000_0010; gens8 = GEN_W'(1);
    @(posedge clk); #1;
    start8 = 1'b0; lat = 1; busy_ok = 1'b1;
    while (done8 !== 1'b1 && lat < 100) begin
      if (busy8 !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check("n8_latency", N'(lat), N'(8));
    check("n8_q", N'(q8), N'(8'b0000_0001));
    check("n8_busy_during", N'(busy_ok), N'(1));

    one256 = '0;
    one256[256] = 1'b1;
    run_job("single_bit_g10", fwd_n(one256, 10), GEN_W'(10), 0, '0, one256, 662);
`ifdef RULE90_REVERSE_CHECK_EN
    check("single_bit_chk_err", N'(chk_err), N'(0));
`endif

    x = rand_vec();
    run_job("gens0", x, '0, 0, '0, x, 2);
    run_job("zero_g5", '0, GEN_W'(5), 0, '0, '0, 332);

    x = rand_vec();
    run_job("start_while_busy", fwd(x), GEN_W'(1), 10, rand_vec(), x, 68);

    // Abort a job in SCAN; q and busy must clear at once and no done may follow.
    @(posedge clk); #1;
    start = 1'b1; data = rand_vec(); gens = GEN_W'(1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check("abort_q", q, '0);
    check("abort_busy", N'(busy), N'(0));
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (i == 2) resetn = 1'b1;
      if (done === 1'b1) seen = 1'b1;
    end
    check("abort_no_done", N'(seen), N'(0));
    x = rand_vec();
    run_job("after_abort", fwd(x), GEN_W'(1), 0, '0, x, 68);

    x = rand_vec();
    d = fwd_n(x, 3);
    run_job("rand_g3", d, GEN_W'(3), 0, '0, x, 200);
    check("rand_g3_roundtrip", fwd_n(q, 3), d);
`ifdef RULE90_REVERSE_CHECK_EN
    check("rand_g3_chk_err", N'(chk_err), N'(0));
`endif

    x = rand_vec();
    run_job("max_gens", fwd_n(x, 255), GEN_W'(255), 0, '0, x, 16832);
`ifdef RULE90_REVERSE_CHECK_EN
    check("max_gens_chk_err", N'(chk_err), N'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
